// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low key matrix one column at a time, assembles the
//   row samples of all four columns into a 16-bit raw frame, and debounces
//   at frame granularity: the key vector only follows the raw frame once
//   STABLE_FRAMES consecutive frames have been identical.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   row_in     matrix rows, active-low, pulled up, asynchronous to clk
//   col_out    column drive, active-low, exactly one bit low
//   key        debounced key levels, bit r*4+c = row r / column c, 1 = pressed
//   key_press  one-cycle strobe when at least one key newly becomes pressed
//   key_code   index of the lowest newly pressed key, held between strobes
//   any_key    OR of key, registered with key
//
// States (column FSM)
//   state | meaning
//   COL0  | column 0 driven low, rows sampled into bits 0,4,8,12 on tick
//   COL1  | column 1 driven low, rows sampled into bits 1,5,9,13 on tick
//   COL2  | column 2 driven low, rows sampled into bits 2,6,10,14 on tick
//   COL3  | column 3 driven low, sample on tick completes the frame
module keypad_scanner #(
  parameter int SCAN_DIV      = 50_000,
  parameter int STABLE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] key,
  output logic        key_press,
  output logic [3:0]  key_code,
  output logic        any_key
);

  localparam int              DivW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
  localparam logic [3:0]      StableMax = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} colState_t;

  logic [3:0]      rowMeta, rowSync;
  logic [DivW-1:0] divCnt;
  logic            tick;
  colState_t       colState;
  logic [15:0]     rawFrame, prevFrame;
  logic            frameDone;
  logic [3:0]      stableCnt, stableNext;
  logic [15:0]     newKeys;
  logic [3:0]      lowestNew;

  // Rows idle high, so the synchroniser resets to "nothing pressed".
  always_ff @(posedge clk) begin
    if (rst) begin
      rowMeta <= 4'hF;
      rowSync <= 4'hF;
    end else begin
      rowMeta <= row_in;
      rowSync <= rowMeta;
    end
  end

  assign tick = (divCnt == DivLast);

  always_ff @(posedge clk) begin
    if (rst)       divCnt <= '0;
    else if (tick) divCnt <= '0;
    else           divCnt <= divCnt + DivW'(1);
  end

  // Sampling on tick happens before the column advances, so each column has
  // had almost a full slot to settle. col_out rotates in step with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      colState  <= COL0;
      col_out   <= 4'b1110;
      rawFrame  <= '0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= tick && (colState == COL3);
      if (tick) begin
        col_out <= {col_out[2:0], col_out[3]};
        case (colState)
          COL0: begin
            {rawFrame[12], rawFrame[8], rawFrame[4], rawFrame[0]} <= ~rowSync;
            colState <= COL1;
          end
          COL1: begin
            {rawFrame[13], rawFrame[9], rawFrame[5], rawFrame[1]} <= ~rowSync;
            colState <= COL2;
          end
          COL2: begin
            {rawFrame[14], rawFrame[10], rawFrame[6], rawFrame[2]} <= ~rowSync;
            colState <= COL3;
          end
          default: begin
            {rawFrame[15], rawFrame[11], rawFrame[7], rawFrame[3]} <= ~rowSync;
            colState <= COL0;
          end
        endcase
      end
    end
  end

  always_comb begin
    stableNext = 4'd1;
    if (rawFrame == prevFrame) begin
      stableNext = (stableCnt >= StableMax) ? StableMax : stableCnt + 4'd1;
    end
  end

  assign newKeys = rawFrame & ~key;

  // Descending scan so the lowest set bit wins.
  always_comb begin
    lowestNew = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (newKeys[i]) lowestNew = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prevFrame <= '0;
      stableCnt <= '0;
      key       <= '0;
      any_key   <= 1'b0;
      key_press <= 1'b0;
      key_code  <= '0;
    end else begin
      key_press <= 1'b0;
      if (frameDone) begin
        stableCnt <= stableNext;
        prevFrame <= rawFrame;
        // Rewriting key while saturated is harmless: newKeys is then zero.
        if (stableNext == StableMax) begin
          key     <= rawFrame;
          any_key <= |rawFrame;
          if (|newKeys) begin
            key_press <= 1'b1;
            key_code  <= lowestNew;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Drives a modelled 4x4 key matrix slot by slot. The reference model sees
//   the keyboard one frame at a time: a frame is the set of keys held while
//   their own column was driven, and key follows a frame once the last
//   STABLE_FRAMES frames are identical. Each frame result is queued and a
//   separate monitor compares it when the DUT publishes its frame result.
module tb_keypad_scanner;
  localparam int SCAN_DIV      = 4;
  localparam int STABLE_FRAMES = 4;
  localparam int FRAME         = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key;
  logic        key_press;
  logic [3:0]  key_code;
  logic        any_key;

  logic [15:0] pressed = '0;

  typedef struct {
    logic [15:0] keyV;
    logic        press;
    logic [3:0]  code;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] hist[$];
  logic [15:0] keyModel = '0;
  logic [3:0]  lastCode = '0;
  logic [15:0] rawAcc   = '0;
  int          slot     = 0;
  int          cyc      = 0;
  int          checks   = 0;
  int          errors   = 0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .STABLE_FRAMES(STABLE_FRAMES)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out), .key(key),
    .key_press(key_press), .key_code(key_code), .any_key(any_key)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Cycle 0 is the first cycle after the last reset edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: frame f's result becomes visible on cycle FRAME*(f+1)+1.
  always @(negedge clk) begin
    if (!rst) begin
      logic [3:0] expCol;
      expCol = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
      check("col_out", {28'd0, col_out}, {28'd0, expCol});
      if (cyc > FRAME && (cyc % FRAME) == 1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow actual=empty required=entry (t=%0t)", $time);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("key", {16'd0, key}, {16'd0, e.keyV});
          check("any_key", {31'd0, any_key}, {31'd0, |e.keyV});
          check("key_press", {31'd0, key_press}, {31'd0, e.press});
          check("key_code", {28'd0, key_code}, {28'd0, e.code});
        end
        check("stable_cnt_bound", {31'd0, (dut.stableCnt <= 4'(STABLE_FRAMES))}, 32'd1);
      end else begin
        check("stray_strobe", {31'd0, key_press}, 32'd0);
      end
    end
  end

  task automatic modelReset();
    hist.delete();
    keyModel = '0;
    lastCode = '0;
    rawAcc   = '0;
    slot     = 0;
  endtask

  task automatic frameEnd();
    exp_t        e;
    logic        allSame;
    logic [15:0] nw;
    logic        found;
    hist.push_back(rawAcc);
    if (hist.size() > STABLE_FRAMES) void'(hist.pop_front());
    allSame = (hist.size() == STABLE_FRAMES);
    foreach (hist[i]) if (hist[i] != rawAcc) allSame = 1'b0;
    e.press = 1'b0;
    if (allSame) begin
      nw = rawAcc & ~keyModel;
      keyModel = rawAcc;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (nw[i] && !found) begin
          found    = 1'b1;
          lastCode = 4'(i);
        end
      end
      e.press = found;
    end
    e.keyV = keyModel;
    e.code = lastCode;
    expQ.push_back(e);
  endtask

  // Called on the negedge of a slot's first cycle; the pattern is settled
  // through the synchroniser well before that slot's sample.
  task automatic runSlot(input logic [15:0] p);
    int c;
    c = slot % 4;
    pressed = p;
    for (int r = 0; r < 4; r++) rawAcc[r*4+c] = p[r*4+c];
    if (c == 3) frameEnd();
    slot++;
    repeat (SCAN_DIV) @(negedge clk);
  endtask

  task automatic runFrames(input logic [15:0] p, input int n);
    repeat (n * 4) runSlot(p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col_out", {28'd0, col_out}, 32'hE);
    check("rst_key", {16'd0, key}, 32'd0);
    check("rst_key_press", {31'd0, key_press}, 32'd0);
    check("rst_any_key", {31'd0, any_key}, 32'd0);
    rst = 1'b0;
    modelReset();

    runFrames(16'h0000, 2);
    runFrames(16'h0040, 8);            // clean press of key 6
    runFrames(16'h0000, 6);            // release, no strobe

    for (int i = 0; i < 40; i++)       // bounce: toggle every 1.5 frames
      runSlot(((i / 6) % 2 == 0) ? 16'h0040 : 16'h0000);
    runFrames(16'h0040, 7);
    runFrames(16'h0000, 6);

    runFrames(16'h1008, 6);            // keys 3 and 12 together
    runFrames(16'h1009, 6);            // add key 0
    runFrames(16'h0000, 6);

    runFrames(16'h0040, 6);            // reset mid-frame while key 6 held
    while (slot % 4 != 2) runSlot(16'h0040);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_key", {16'd0, key}, 32'd0);
    check("midrst_col_out", {28'd0, col_out}, 32'hE);
    check("midrst_any_key", {31'd0, any_key}, 32'd0);
    rst = 1'b0;
    modelReset();
    runFrames(16'h0040, 6);
    runFrames(16'h0000, 6);

    runFrames(16'h8000, 40);           // saturation
    runFrames(16'h0000, 6);

    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 2) == 0) p = 16'h0001 << $urandom_range(0, 15);
      else                           p = 16'($urandom & $urandom & $urandom);
      repeat ($urandom_range(1, 28)) runSlot(p);
    end

    runFrames(16'h0000, 2);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the game core. Scans the 4x4 matrix keyboard, debounces whole scan frames, and drives the 16-bit key level vector that the core compares against its one-hot target.
- Also gives a single-cycle press strobe and the encoded key index, for tone and feedback logic.
- Bit i of key is the key at row i/4, column i%4, matching the core's pos encoding.

Parameters:
- SCAN_DIV, 50_000: clk cycles per column slot (1 ms at 50 MHz). Must be >= 2.
- STABLE_FRAMES, 4: number of consecutive identical raw frames required before key updates. Range 1..15.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- row_in, input, 4: keyboard rows. Active-low; externally pulled up. Asynchronous to clk.
- col_out, output, 4: column drive. Active-low; exactly one bit is low at any time.
- key, output, 16: debounced key level vector. 1 = pressed.
- key_press, output, 1: one-clk strobe when a key newly becomes pressed.
- key_code, output, 4: index of the lowest newly pressed key. Valid while key_press = 1; holds its value otherwise.
- any_key, output, 1: OR-reduction of key.

Behaviour:
- Reset values (rst = 1 at a clk edge):
  - col_out = 4'b1110 (column 0 driven).
  - key = 0, key_press = 0, key_code = 0, any_key = 0.
  - Prescaler, column index, raw frame, previous frame and stable counter all cleared.
  - Reset asserted mid-frame discards the partial frame. Scanning restarts at column 0 on the first cycle after rst deasserts.
- Input synchronisation: row_in passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = 1 on the cycle the count equals SCAN_DIV-1.
- Column state machine: states COL0 -> COL1 -> COL2 -> COL3 -> COL0, advancing on tick.
  - col_out for column c is all ones except bit c = 0.
- Sampling:
  - On tick, before advancing, capture ~row_sync into raw bits {r*4+c} for r = 0..3, where c is the current column.
  - This gives a full SCAN_DIV-2 cycles of settle time after each column change.
- Frame completion: the tick in COL3 completes the frame. The frame compare happens on the following clk cycle, frame_done.
- Debounce, on frame_done:
  - If raw equals prev: stable counter increments and saturates at STABLE_FRAMES.
  - Otherwise: counter = 1.
  - prev <= raw in both cases.
  - When the counter reaches STABLE_FRAMES, or is already saturated, key <= raw.
  - A raw change restarts the count; key holds its old value until the new pattern has been stable for STABLE_FRAMES frames.
- Latency: from a stable row change to the key update is between STABLE_FRAMES and STABLE_FRAMES+1 frames (x 4*SCAN_DIV clks), plus 3 clks.
- Press detection:
  - new = key_next & ~key.
  - If new != 0 when key updates: key_press = 1 for exactly that one cycle, and key_code = index of the lowest set bit of new.
  - Releases and unchanged updates produce no strobe.
  - Simultaneous multiple new presses produce one strobe, with the lowest index.
- Ghosting: no blocking logic. Multi-key patterns pass through unchanged; the consumer rejects any pattern that is not one-hot.
- any_key is registered together with key (same cycle).

Test Plan:
- Reset check: hold rst 3 cycles -> col_out = 1110, key = 0000, key_press = 0. After release, col_out steps 1110 -> 1101 -> 1011 -> 0111 at SCAN_DIV-cycle intervals.
- Clean press (SCAN_DIV = 4, STABLE_FRAMES = 4): model key 6 (row 1, col 2) pulling row_in[1] low while col_out[2] = 0, held steady -> key = 16'h0040 within 5 frames. key_press pulses once with key_code = 6; any_key = 1.
- Bounce: toggle key 6 every 1.5 frames for 10 frames, then hold -> key stays 0 during the bouncing. Exactly one key_press, 4 to 5 frames after the hold begins.
- Release and multi-press:
  - Release key 6 -> key returns to 0 with no strobe.
  - Press keys 3 and 12 together -> key = 16'h1008, one strobe, key_code = 3.
  - Then add key 0 -> key = 16'h1009, strobe with key_code = 0.
- Reset mid-frame: assert rst during COL2 while key = 16'h0040 -> next cycle key = 0, col_out = 1110. Because key was cleared, the still-held key is re-detected after STABLE_FRAMES frames and produces one new strobe.
- Saturation: hold key 15 for 40 frames -> key = 16'h8000 throughout, a single strobe, and the stable counter never exceeds STABLE_FRAMES.
